circuit_sweep_ctrl: RTL and testbench

//   Sequencer for the 4-output select/data gate network (s2,s1,s0,i -> y,y2,y3,y4).

---
 rtl/circuit_sweep_ctrl_if.sv | 22 ++
 rtl/circuit_sweep_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_circuit_sweep_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/circuit_sweep_ctrl_if.sv
// Result stream from the sweep sequencer to its consumer: valid/ready handshake
// carrying the vector index and the four sampled network outputs.
interface circuit_sweep_ctrl_if;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_index;
    logic [3:0] res_data;

    modport master (
        output res_valid,
        output res_index,
        output res_data,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_index,
        input  res_data,
        output res_ready
    );
endinterface

// File: rtl/circuit_sweep_ctrl.sv
// Sweeps {s2,s1,s0,i} of the 4-output gate network from VEC_FIRST to VEC_LAST and
// streams each settled sample out. Define CIRCUIT_SWEEP_CHECK_EN for the golden-model checker.
module circuit_sweep_ctrl #(
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned VEC_FIRST = 0,
    parameter int unsigned VEC_LAST  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2:0]           sel_o,
    output logic                 i_drv_o,
    circuit_sweep_ctrl_if.master res,
    input  logic [3:0]           y_in_i
`ifdef CIRCUIT_SWEEP_CHECK_EN
    ,
    output logic                 mismatch_o,
    output logic [4:0]           err_count_o
`endif
);

    localparam logic [3:0] VEC_FIRST_C = VEC_FIRST[3:0];
    localparam logic [3:0] VEC_LAST_C  = VEC_LAST[3:0];
    localparam logic [3:0] RELOAD_C    = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] vec_q,   vec_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       valid_q, valid_d;
    logic [3:0] index_q, index_d;
    logic [3:0] data_q,  data_d;
    logic       handshake;

`ifdef CIRCUIT_SWEEP_CHECK_EN
    logic       mismatch_q, mismatch_d;
    logic [4:0] err_q,      err_d;

    // Reference behaviour of the network; v = {s2,s1,s0,i}, result = {y4,y3,y2,y}.
    function automatic logic [3:0] golden(input logic [3:0] v);
        logic s2, s1, s0, i;
        logic y, y2, y3, y4;
        {s2, s1, s0, i} = v;
        y  = (~s2 & s1 & ~s0 & ~i) | (s2 & ~s1 & s0 & i);
        y2 = (~s2 & ~s0 & i) | (~s1 & i) | s2 | s1 | s0;
        y3 = (~s2 & s1 & s0 & i) | (s2 & ~s1 & i);
        y4 = (~s2 & ~s1 & s0) | (~s2 & s1 & ~s0) | (~s2 & ~s0 & i);
        return {y4, y3, y2, y};
    endfunction
`endif

    assign handshake = valid_q & res.res_ready;

    // NOTE: every _d is given its hold value first, so no path through this block
    // leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        index_d = index_q;
        data_d  = data_q;
`ifdef CIRCUIT_SWEEP_CHECK_EN
        mismatch_d = mismatch_q;
        err_d      = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_SETTLE;
                    vec_d   = VEC_FIRST_C;
                    cnt_d   = RELOAD_C;
`ifdef CIRCUIT_SWEEP_CHECK_EN
                    mismatch_d = 1'b0;
                    err_d      = '0;
`endif
                end
            end

            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_EMIT;
                    valid_d = 1'b1;
                    index_d = vec_q;
                    data_d  = y_in_i;
`ifdef CIRCUIT_SWEEP_CHECK_EN
                    mismatch_d = (y_in_i != golden(vec_q));
                    if ((y_in_i != golden(vec_q)) && (err_q != 5'd31)) begin
                        err_d = err_q + 5'd1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_EMIT: begin
                if (handshake) begin
                    valid_d = 1'b0;
`ifdef CIRCUIT_SWEEP_CHECK_EN
                    mismatch_d = 1'b0;
`endif
                    if (index_q == VEC_LAST_C) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETTLE;
                        vec_d   = index_q + 4'd1;
                        cnt_d   = RELOAD_C;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides anything decided above, including a same-cycle handshake.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            vec_d   = vec_q;
            cnt_d   = cnt_q;
`ifdef CIRCUIT_SWEEP_CHECK_EN
            mismatch_d = 1'b0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
`ifdef CIRCUIT_SWEEP_CHECK_EN
            mismatch_q <= 1'b0;
            err_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
`ifdef CIRCUIT_SWEEP_CHECK_EN
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
`endif
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign sel_o         = vec_q[3:1];
    assign i_drv_o       = vec_q[0];
    assign res.res_valid = valid_q;
    assign res.res_index = index_q;
    assign res.res_data  = data_q;

`ifdef CIRCUIT_SWEEP_CHECK_EN
    assign mismatch_o  = mismatch_q;
    assign err_count_o = err_q;
`endif

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Directed bench for circuit_sweep_ctrl: full sweep, backpressure, single-vector sweep,
// abort, reset mid-sweep; with CIRCUIT_SWEEP_CHECK_EN also the stuck-y2 checker run.
module tb_circuit_sweep_ctrl;

    typedef struct {
        logic [3:0] idx;
        logic [3:0] data;
    } vec_t;

    vec_t tbl[16];

    int n_cmp = 0;
    int n_err = 0;

    logic clk = 1'b0;
    logic rst, start, abort, start1, abort1, y2_stuck;
    logic busy, done, i_drv, busy1, done1, i_drv1;
    logic [2:0] sel, sel1;
    logic [3:0] y_in, y_in1;

    always #5 clk = ~clk;

    circuit_sweep_ctrl_if sif ();
    circuit_sweep_ctrl_if sif1 ();

`ifdef CIRCUIT_SWEEP_CHECK_EN
    logic       mismatch, mismatch1;
    logic [4:0] err_count, err_count1;
`endif

    // Gate network under sweep; y_in = {y4,y3,y2,y}
    function automatic logic [3:0] net(input logic [3:0] v);
        logic s2, s1, s0, i;
        logic y, y2, y3, y4;
        {s2, s1, s0, i} = v;
        y  = (~s2 & s1 & ~s0 & ~i) | (s2 & ~s1 & s0 & i);
        y2 = (~s2 & ~s0 & i) | (~s1 & i) | s2 | s1 | s0;
        y3 = (~s2 & s1 & s0 & i) | (s2 & ~s1 & i);
        y4 = (~s2 & ~s1 & s0) | (~s2 & s1 & ~s0) | (~s2 & ~s0 & i);
        return {y4, y3, y2, y};
    endfunction

    assign y_in  = net({sel, i_drv}) & ~{2'b00, y2_stuck, 1'b0};
    assign y_in1 = net({sel1, i_drv1});

    circuit_sweep_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .abort_i (abort),
        .busy_o  (busy),
        .done_o  (done),
        .sel_o   (sel),
        .i_drv_o (i_drv),
        .res     (sif),
        .y_in_i  (y_in)
`ifdef CIRCUIT_SWEEP_CHECK_EN
        ,
        .mismatch_o  (mismatch),
        .err_count_o (err_count)
`endif
    );

    circuit_sweep_ctrl #(
        .SETTLE    (1),
        .VEC_FIRST (9),
        .VEC_LAST  (9)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start1),
        .abort_i (abort1),
        .busy_o  (busy1),
        .done_o  (done1),
        .sel_o   (sel1),
        .i_drv_o (i_drv1),
        .res     (sif1),
        .y_in_i  (y_in1)
`ifdef CIRCUIT_SWEEP_CHECK_EN
        ,
        .mismatch_o  (mismatch1),
        .err_count_o (err_count1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for res_valid on the main DUT, counting a timeout as a failure.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!sif.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(sif.res_valid), 32'd1);
    endtask

    task automatic expect_result(input int i);
        wait_valid($sformatf("res%0d", i));
        check($sformatf("res%0d_index", i), 32'(sif.res_index), 32'(tbl[i].idx));
        check($sformatf("res%0d_data", i), 32'(sif.res_data), 32'(tbl[i].data));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, done_cnt, done_c;
        bit seen_done;

        // Hand-computed responses {y4,y3,y2,y} for every vector {s2,s1,s0,i}
        tbl[0]  = '{4'd0,  4'b0000};
        tbl[1]  = '{4'd1,  4'b1010};
        tbl[2]  = '{4'd2,  4'b1010};
        tbl[3]  = '{4'd3,  4'b1010};
        tbl[4]  = '{4'd4,  4'b1011};
        tbl[5]  = '{4'd5,  4'b1010};
        tbl[6]  = '{4'd6,  4'b0010};
        tbl[7]  = '{4'd7,  4'b0110};
        tbl[8]  = '{4'd8,  4'b0010};
        tbl[9]  = '{4'd9,  4'b0110};
        tbl[10] = '{4'd10, 4'b0010};
        tbl[11] = '{4'd11, 4'b0111};
        tbl[12] = '{4'd12, 4'b0010};
        tbl[13] = '{4'd13, 4'b0010};
        tbl[14] = '{4'd14, 4'b0010};
        tbl[15] = '{4'd15, 4'b0010};

        rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        y2_stuck = 1'b0; sif.res_ready = 1'b0; sif1.res_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_valid", 32'(sif.res_valid), 0);
        check("rst_sel",   32'({sel, i_drv}), 0);
        check("rst_index", 32'(sif.res_index), 0);
        check("rst_data",  32'(sif.res_data), 0);
        check("rst_busy1", 32'(busy1), 0);
`ifdef CIRCUIT_SWEEP_CHECK_EN
        check("rst_mismatch", 32'(mismatch), 0);
        check("rst_err",      32'(err_count), 0);
`endif
        rst = 1'b0;

        // Full sweep, ready tied high: result k expected on cycle 3+3k after start
        sif.res_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; done_cnt = 0; done_c = 0;
        for (int c = 1; c <= 55; c++) begin
            if (sif.res_valid) begin
                if (k < 16) begin
                    check($sformatf("t1_index%0d", k), 32'(sif.res_index), 32'(tbl[k].idx));
                    check($sformatf("t1_data%0d", k),  32'(sif.res_data),  32'(tbl[k].data));
                    check($sformatf("t1_drive%0d", k), 32'({sel, i_drv}),  32'(tbl[k].idx));
                    check($sformatf("t1_cycle%0d", k), 32'(c), 32'(3 + 3 * k));
`ifdef CIRCUIT_SWEEP_CHECK_EN
                    check($sformatf("t1_mismatch%0d", k), 32'(mismatch), 0);
`endif
                end
                k++;
            end
            if (done) begin
                done_cnt++;
                done_c = c;
            end
            @(negedge clk);
        end
        check("t1_results",    32'(k), 16);
        check("t1_done_count", 32'(done_cnt), 1);
        check("t1_done_cycle", 32'(done_c), 49);
        check("t1_idle_busy",  32'(busy), 0);
        check("t1_idle_hold",  32'({sel, i_drv}), 15);

        // Backpressure at index 3
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            expect_result(i);
            if (i < 3) @(negedge clk);
        end
        sif.res_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check($sformatf("bp_valid%0d", n), 32'(sif.res_valid), 1);
            check($sformatf("bp_index%0d", n), 32'(sif.res_index), 3);
            check($sformatf("bp_data%0d", n),  32'(sif.res_data), 32'(4'b1010));
            check($sformatf("bp_drive%0d", n), 32'({sel, i_drv}), 32'(4'b0011));
            @(negedge clk);
        end
        sif.res_ready = 1'b1;
        for (int i = 4; i <= 15; i++) begin
            @(negedge clk);
            expect_result(i);
        end
        @(negedge clk);
        check("bp_done_pulse", 32'(done), 1);
        @(negedge clk);
        check("bp_done_clear", 32'(done), 0);
        check("bp_idle",       32'(busy), 0);

        // Single-vector sweep: SETTLE=1, VEC_FIRST=VEC_LAST=9
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("one_c1_valid", 32'(sif1.res_valid), 0);
        check("one_c1_busy",  32'(busy1), 1);
        @(negedge clk);
        check("one_c2_valid", 32'(sif1.res_valid), 1);
        check("one_c2_index", 32'(sif1.res_index), 9);
        check("one_c2_data",  32'(sif1.res_data), 32'(4'b0110));
        @(negedge clk);
        check("one_c3_done",  32'(done1), 1);
        check("one_c3_valid", 32'(sif1.res_valid), 0);
        @(negedge clk);
        check("one_c4_done",  32'(done1), 0);
        check("one_c4_busy",  32'(busy1), 0);

        // Abort in EMIT of index 6, together with a handshake
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            expect_result(i);
            if (i < 6) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",  32'(busy), 0);
        check("abort_valid", 32'(sif.res_valid), 0);
        check("abort_hold",  32'({sel, i_drv}), 6);
        seen_done = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (done || busy) seen_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen_done), 0);

        // Restart from index 0; start while busy is ignored; rst in SETTLE
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("restart_valid", 32'(sif.res_valid), 1);
        check("restart_index", 32'(sif.res_index), 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_result(1);
        @(negedge clk);
        expect_result(2);
        @(negedge clk);
        check("pre_rst_busy",  32'(busy), 1);
        check("pre_rst_drive", 32'({sel, i_drv}), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",  32'(busy), 0);
        check("midrst_done",  32'(done), 0);
        check("midrst_valid", 32'(sif.res_valid), 0);
        check("midrst_drive", 32'({sel, i_drv}), 0);
        check("midrst_index", 32'(sif.res_index), 0);
        check("midrst_data",  32'(sif.res_data), 0);

`ifdef CIRCUIT_SWEEP_CHECK_EN
        // y2 stuck at 0: every vector whose golden y2 is 1 must flag
        y2_stuck = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 15; i++) begin
            wait_valid($sformatf("chk%0d", i));
            check($sformatf("chk_index%0d", i),    32'(sif.res_index), 32'(tbl[i].idx));
            check($sformatf("chk_data%0d", i),     32'(sif.res_data), 32'(tbl[i].data & 4'b1101));
            check($sformatf("chk_mismatch%0d", i), 32'(mismatch), 32'(tbl[i].data[1]));
            @(negedge clk);
        end
        check("chk_done", 32'(done), 1);
        check("chk_err",  32'(err_count), 15);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("chk_err_clear", 32'(err_count), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        y2_stuck = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
